fp_result_collector: RTL and testbench
======================================

Name: fp_result_collector

Overview:
- Sink-side companion to the add_sub_main FP adder/subtractor.
- Tracks each issued operation through the adder's fixed pipeline latency, then captures the matching `result` word.
- Classifies each captured result (IEEE-754 single precision) and buffers result + class + op in a first-word-fall-through (FWFT) FIFO, drained by a valid/ready reader.
- Keeps per-class event counters for on-chip checking and coverage readout.

Parameters:
- WIDTH, 32, operand/result width; only 32 (binary32) is supported.
- LATENCY, 1, cycles from issue (`in_valid` sampled) to `result` valid at add_sub_main output; legal range 1..8.
- DEPTH, 16, FIFO entries; power of two, 2..256.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an operation is presented to add_sub_main this cycle.
- operation_select  input  1  op of the issued operation (1 = add, 0 = sub).
- result  input  WIDTH  add_sub_main result bus.
- clear  input  1  synchronous flush of FIFO, counters and sticky flags.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  reader accepts the head.
- out_result  output  WIDTH  head result word.
- out_class  output  3  head class.
- out_op  output  1  head operation_select.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky; a capture was dropped.
- drop_cnt  output  CNT_W  dropped captures, saturating.
- nan_cnt, inf_cnt, zero_cnt, sub_cnt  output  CNT_W each  class counters, saturating.

Behaviour:
- Reset (`rst`=1 at posedge): all state is cleared.
  - `out_valid`=0, `out_result`=0, `out_class`=0, `out_op`=0, `level`=0.
  - `overflow`=0 and all counters 0.
  - Delay line is cleared, so in-flight operations are discarded.
  - Reset has priority over every other input.
- Delay line: LATENCY-deep shift register of {valid, op}, loaded from {`in_valid`, `operation_select`} each cycle.
  - The tap (stage LATENCY-1 output) qualifies the capture: on a tap-valid cycle, `result` is sampled that same edge.
  - Capture is exactly LATENCY cycles after issue, with back-to-back issue at full rate.
- Classification of the captured word (exp = bits[30:23], frac = bits[22:0]):
  - 0 zero: exp=0, frac=0.
  - 1 subnormal: exp=0, frac≠0.
  - 2 normal: exp 1..254.
  - 3 infinity: exp=255, frac=0.
  - 4 qNaN: exp=255, frac[22]=1.
  - 5 sNaN: exp=255, frac[22]=0, frac≠0.
  - Sign bit does not affect the class.
- Counters, incremented on each capture (including dropped captures) and saturating at all-ones:
  - `zero_cnt`: class 0.
  - `sub_cnt`: class 1.
  - `inf_cnt`: class 3.
  - `nan_cnt`: class 4 or 5.
- FIFO (FWFT):
  - `out_*` reflect the head whenever `level`>0; `out_valid` = (`level`≠0).
  - Pop occurs when `out_valid` && `out_ready`.
  - Push is accepted when `level`<DEPTH, or when `level`==DEPTH and a pop happens in the same cycle; `level` is then unchanged.
  - Push into a full FIFO without a pop: entry dropped, `overflow` set (sticky), `drop_cnt`++. Existing contents are untouched.
  - Simultaneous push and pop on an empty FIFO: not possible (FWFT, `out_valid`=0); the push completes and `out_valid` rises the next cycle.
  - With `level`=0, `out_result`/`out_class`/`out_op` hold their last values and are don't-care to the reader.
  - Pointers wrap modulo DEPTH.
- Capture-to-visibility latency: 1 cycle (entry pushed at edge N is at the head after edge N if the FIFO was empty).
- `clear`:
  - Same effect as reset on FIFO, counters and `overflow`.
  - Does NOT clear the delay line; in-flight operations are still captured afterwards.
  - A capture in the same cycle as `clear` is discarded and not counted.
- `overflow` and `drop_cnt` clear only via `rst` or `clear`.

Optional Feature:
- Macro: FP_COLLECTOR_STATS_EN.
- Defined: `nan_cnt`/`inf_cnt`/`zero_cnt`/`sub_cnt` are implemented as above.
- Undefined: class counter logic is not compiled; these four ports are driven constant 0. Classification, FIFO, `overflow` and `drop_cnt` are unaffected.

Test Plan:
- LATENCY=1. Issue `in_valid` with `operation_select`=1 for one cycle; `result`=32'h40400000 one cycle later → `out_valid` next cycle with `out_result`=32'h40400000, `out_class`=2, `out_op`=1.
- Back-to-back captures of 32'h7f800000, 32'h7fc00000, 32'h7f800001, 32'h00000000, 32'h00000001, `out_ready`=1 → classes 3,4,5,0,1 in order; `inf_cnt`=1, `nan_cnt`=2, `zero_cnt`=1, `sub_cnt`=1.
- DEPTH=16, `out_ready`=0, 18 captures → `level`=16, `overflow`=1, `drop_cnt`=2; first 16 words drain in issue order.
- FIFO full with `out_ready`=1 and capture in the same cycle → `level` stays 16, `overflow` stays 0.
- `rst` asserted mid-stream with 3 operations in flight and `level`=5 → next cycle all outputs 0; no later captures from those operations.
- Without FP_COLLECTOR_STATS_EN, 10 NaN captures → `nan_cnt`=0 and `out_class`=4 for each entry.

Source files
------------

// File: rtl/fp_result_collector.sv
// Result sink for add_sub_main: aligns results to issued ops, classifies them and queues them in a FWFT FIFO.
// Optional macro FP_COLLECTOR_STATS_EN enables the per-class event counters.
module fp_result_collector #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     operation_select,
    input  logic [WIDTH-1:0]         result,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [2:0]               out_class,
    output logic                     out_op,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         nan_cnt,
    output logic [CNT_W-1:0]         inf_cnt,
    output logic [CNT_W-1:0]         zero_cnt,
    output logic [CNT_W-1:0]         sub_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = WIDTH + 4;

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_SUB  = 3'd1;
    localparam logic [2:0] CLS_NORM = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_QNAN = 3'd4;
    localparam logic [2:0] CLS_SNAN = 3'd5;

    logic [LATENCY-1:0] dly_v;
    logic [LATENCY-1:0] dly_op;
    logic               tap_v;
    logic               tap_op;
    logic               capture;
    logic               pop;
    logic               push;
    logic               drop;
    logic [2:0]         cap_class;
    logic [EW-1:0]      cap_entry;
    logic [EW-1:0]      head_nxt;
    logic [LW-1:0]      level_nxt;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      rd_ptr_inc;
    logic [EW-1:0]      mem [DEPTH];

    // Issue tracker: the tap marks the cycle the matching result is on the bus
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_v  <= '0;
            dly_op <= '0;
        end else begin
            dly_v[0]  <= in_valid;
            dly_op[0] <= operation_select;
            for (int i = 1; i < int'(LATENCY); i++) begin
                dly_v[i]  <= dly_v[i-1];
                dly_op[i] <= dly_op[i-1];
            end
        end
    end

    assign tap_v  = dly_v[LATENCY-1];
    assign tap_op = dly_op[LATENCY-1];

    // binary32 classification; sign is ignored
    always_comb begin
        cap_class = CLS_NORM;
        if (result[30:23] == 8'd0) begin
            cap_class = (result[22:0] == 23'd0) ? CLS_ZERO : CLS_SUB;
        end else if (result[30:23] == 8'hff) begin
            if (result[22:0] == 23'd0) begin
                cap_class = CLS_INF;
            end else if (result[22]) begin
                cap_class = CLS_QNAN;
            end else begin
                cap_class = CLS_SNAN;
            end
        end
    end

    assign cap_entry  = {tap_op, cap_class, result};
    assign capture    = tap_v && !clear;
    assign pop        = out_valid && out_ready;
    assign push       = capture && ((level != LW'(DEPTH)) || pop);
    assign drop       = capture && !push;
    assign level_nxt  = level + LW'(push) - LW'(pop);
    assign rd_ptr_inc = rd_ptr + AW'(1);

    // Next head: fresh capture when the queue would otherwise be empty, else the following slot
    always_comb begin
        head_nxt = {out_op, out_class, out_result};
        if (push && ((level == LW'(0)) || (pop && (level == LW'(1))))) begin
            head_nxt = cap_entry;
        end else if (pop && (level > LW'(1))) begin
            head_nxt = mem[rd_ptr_inc];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= cap_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_class  <= '0;
            out_op     <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            level                           <= level_nxt;
            out_valid                       <= (level_nxt != LW'(0));
            {out_op, out_class, out_result} <= head_nxt;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef FP_COLLECTOR_STATS_EN
    // Class counters see every capture, including ones dropped at a full FIFO
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            nan_cnt  <= '0;
            inf_cnt  <= '0;
            zero_cnt <= '0;
            sub_cnt  <= '0;
        end else if (capture) begin
            case (cap_class)
                CLS_ZERO: if (zero_cnt != '1) zero_cnt <= zero_cnt + CNT_W'(1);
                CLS_SUB:  if (sub_cnt  != '1) sub_cnt  <= sub_cnt  + CNT_W'(1);
                CLS_INF:  if (inf_cnt  != '1) inf_cnt  <= inf_cnt  + CNT_W'(1);
                CLS_QNAN,
                CLS_SNAN: if (nan_cnt  != '1) nan_cnt  <= nan_cnt  + CNT_W'(1);
                default:  ;
            endcase
        end
    end
`else
    assign nan_cnt  = '0;
    assign inf_cnt  = '0;
    assign zero_cnt = '0;
    assign sub_cnt  = '0;
`endif

endmodule

// File: tb/tb_fp_result_collector.sv
// Self-checking bench for fp_result_collector: directed scenarios plus random traffic against a queue-based model.
module tb_fp_result_collector;

    localparam int LAT = 3;
    localparam int DEP = 16;
    localparam int CW  = 16;
`ifdef FP_COLLECTOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, in_valid, operation_select, clear, out_ready;
    logic [31:0]   result;
    logic          out_valid, out_op, overflow;
    logic [31:0]   out_result;
    logic [2:0]    out_class;
    logic [4:0]    level;
    logic [CW-1:0] drop_cnt, nan_cnt, inf_cnt, zero_cnt, sub_cnt;

    always #5 clk = ~clk;

    fp_result_collector #(.WIDTH(32), .LATENCY(LAT), .DEPTH(DEP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .operation_select(operation_select),
        .result(result), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_class(out_class), .out_op(out_op), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt), .nan_cnt(nan_cnt), .inf_cnt(inf_cnt),
        .zero_cnt(zero_cnt), .sub_cnt(sub_cnt)
    );

    typedef struct { int due; bit op; } fl_t;
    typedef struct { int due; logic [31:0] val; } sc_t;
    typedef struct { logic [31:0] r; int c; bit op; } ent_t;

    fl_t  inflight[$];
    sc_t  sched[$];
    ent_t fifo[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   m_ovf;
    int   m_drop, m_nan, m_inf, m_zero, m_sub;
    ent_t last;

    function automatic int cls(logic [31:0] w);
        logic [7:0]  e = w[30:23];
        logic [22:0] f = w[22:0];
        if (e == 8'd0)   return (f == 0) ? 0 : 1;
        if (e == 8'd255) return (f == 0) ? 3 : (f[22] ? 4 : 5);
        return 2;
    endfunction

    function automatic int sat(int x);
        return (x < (1 << CW) - 1) ? x + 1 : x;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        fifo.delete();
        m_ovf = 0; m_drop = 0; m_nan = 0; m_inf = 0; m_zero = 0; m_sub = 0;
        last = '{32'd0, 0, 1'b0};
    endtask

    task automatic check_all();
        chk("out_valid", 64'(out_valid), 64'(fifo.size() != 0));
        chk("level", 64'(level), 64'(fifo.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("nan_cnt", 64'(nan_cnt), STATS ? 64'(m_nan) : 64'd0);
        chk("inf_cnt", 64'(inf_cnt), STATS ? 64'(m_inf) : 64'd0);
        chk("zero_cnt", 64'(zero_cnt), STATS ? 64'(m_zero) : 64'd0);
        chk("sub_cnt", 64'(sub_cnt), STATS ? 64'(m_sub) : 64'd0);
        chk("out_result", 64'(out_result), 64'(last.r));
        chk("out_class", 64'(out_class), 64'(last.c));
        chk("out_op", 64'(out_op), 64'(last.op));
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare
    task automatic step(bit iv, bit op, bit rdy, bit clr, bit rs);
        bit cap, cop, popd, full;
        int c;
        while (sched.size() > 0 && sched[0].due < cyc) void'(sched.pop_front());
        if (sched.size() > 0 && sched[0].due == cyc) result = sched[0].val;
        else result = $urandom;
        in_valid = iv; operation_select = op; out_ready = rdy; clear = clr; rst = rs;
        @(posedge clk);
        cap = 0; cop = 0;
        if (rs) begin
            inflight.delete();
            model_clear();
        end else begin
            if (inflight.size() > 0 && inflight[0].due == cyc) begin
                cap = 1; cop = inflight[0].op; void'(inflight.pop_front());
            end
            if (iv) inflight.push_back('{cyc + LAT, op});
            if (clr) begin
                model_clear();
            end else begin
                popd = (fifo.size() > 0) && rdy;
                full = (fifo.size() == DEP);
                if (popd) void'(fifo.pop_front());
                if (cap) begin
                    c = cls(result);
                    case (c)
                        0: m_zero = sat(m_zero);
                        1: m_sub  = sat(m_sub);
                        3: m_inf  = sat(m_inf);
                        4, 5: m_nan = sat(m_nan);
                        default: ;
                    endcase
                    if (!full || popd) fifo.push_back('{result, c, cop});
                    else begin m_ovf = 1; m_drop = sat(m_drop); end
                end
                if (fifo.size() > 0) last = fifo[0];
            end
        end
        cyc++;
        #1;
        check_all();
    endtask

    task automatic issue(bit op, logic [31:0] val, bit rdy);
        sched.push_back('{cyc + LAT, val});
        step(1, op, rdy, 0, 0);
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, rdy, 0, 0);
    endtask

    initial begin
        logic [31:0] pool [10];
        logic [31:0] t2v [5];
        pool = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h807fffff, 32'h40400000,
                 32'h7f800000, 32'hff800000, 32'h7fc00000, 32'h7f800001, 32'h7fbfffff};
        t2v  = '{32'h7f800000, 32'h7fc00000, 32'h7f800001, 32'h00000000, 32'h00000001};
        rst = 1; in_valid = 0; operation_select = 0; clear = 0; out_ready = 0; result = 0;
        model_clear();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_level", 64'(level), 64'd0);

        // Single add result appears LAT+1 edges after issue
        issue(1, 32'h40400000, 0);
        idle(LAT, 0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_result", 64'(out_result), 64'h40400000);
        chk("t1_class", 64'(out_class), 64'd2);
        chk("t1_op", 64'(out_op), 64'd1);
        idle(2, 1);

        // Special values back to back
        for (int i = 0; i < 5; i++) issue(i[0], t2v[i], 1);
        idle(LAT + 2, 1);
        chk("t2_inf", 64'(inf_cnt), STATS ? 64'd1 : 64'd0);
        chk("t2_nan", 64'(nan_cnt), STATS ? 64'd2 : 64'd0);
        chk("t2_zero", 64'(zero_cnt), STATS ? 64'd1 : 64'd0);
        chk("t2_sub", 64'(sub_cnt), STATS ? 64'd1 : 64'd0);

        // Overfill with the reader stalled
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 18; i++) issue(1, 32'h3f800000 + 32'(i), 0);
        idle(LAT, 0);
        chk("t3_level", 64'(level), 64'd16);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_drop", 64'(drop_cnt), 64'd2);
        for (int i = 0; i < 16; i++) begin
            chk("t3_head", 64'(out_result), 64'(32'h3f800000 + 32'(i)));
            step(0, 0, 1, 0, 0);
        end
        chk("t3_empty", 64'(out_valid), 64'd0);

        // Full FIFO, pop and push on the same edge
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 17; i++) issue(0, 32'h41000000 + 32'(i), 0);
        idle(LAT - 1, 0);
        step(0, 0, 1, 0, 0);
        chk("t4_level", 64'(level), 64'd16);
        chk("t4_ovf", 64'(overflow), 64'd0);
        chk("t4_head", 64'(out_result), 64'h41000001);

        // Reset with operations in flight
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) issue(1, 32'h42000000 + 32'(i), 0);
        idle(LAT, 0);
        chk("t5_level", 64'(level), 64'd5);
        for (int i = 0; i < 3; i++) issue(1, 32'h7f800000, 0);
        step(0, 0, 0, 0, 1);
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_result", 64'(out_result), 64'd0);
        idle(LAT + 2, 0);
        chk("t5_after_level", 64'(level), 64'd0);
        chk("t5_after_inf", 64'(inf_cnt), 64'd0);

        // Ten quiet NaNs
        for (int i = 0; i < 10; i++) issue(1, {i[0], 31'h7fc00000 | 31'(i)}, 0);
        idle(LAT, 0);
        chk("t6_nan_cnt", 64'(nan_cnt), STATS ? 64'd10 : 64'd0);
        for (int i = 0; i < 10; i++) begin
            chk("t6_class", 64'(out_class), 64'd4);
            step(0, 0, 1, 0, 0);
        end

        // Random traffic
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            bit iv, rdy, clr, rs;
            logic [31:0] v;
            iv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 59) == 0);
            rs  = ($urandom_range(0, 149) == 0);
            v   = ($urandom_range(0, 2) == 0) ? 32'($urandom) : pool[$urandom_range(0, 9)];
            if (iv && !rs) sched.push_back('{cyc + LAT, v});
            step(iv, 1'($urandom), rdy, clr, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
